// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: sequencer state encoding and default geometry shared by the
// sequencer and its return stack.
package pc_seq_pkg;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_INSTR_W = 9;
    localparam int DEF_STACK_DEPTH = 4;
    localparam logic [8:0] DEF_HALT_INSTR = 9'h1FF;
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, EXEC, HALT} state_e;
endpackage

// File: rtl/pc_sequencer_call_stack.sv
// call_stack: return-address LIFO; the owner guarantees no push when full
// and no pop when empty.
module call_stack
    import pc_seq_pkg::*;
#(
    parameter int DEPTH = DEF_STACK_DEPTH,
    parameter int W = DEF_ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [W-1:0] mem_q [DEPTH];
    logic [IW:0] cnt_q;
    logic [IW-1:0] top;
    assign top = IW'(cnt_q - 1'b1);
    assign dout_o = mem_q[top];
    assign full_o = cnt_q == (IW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_i) begin
            mem_q[cnt_q[IW-1:0]] <= din_i;
            cnt_q <= cnt_q + 1'b1;
        end else if (pop_i) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetches instructions over req/ack, issues each for one cycle
// and resolves the next pc from sequential flow, jumps, calls and returns.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(DEF_HALT_INSTR)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    input  logic               mem_ack_i,
    input  logic [INSTR_W-1:0] mem_data_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic               instr_valid_o,
    input  logic               exec_done_i,
    input  logic               jump_taken_i,
    input  logic               call_i,
    input  logic               ret_i,
    input  logic [ADDR_W-1:0]  jump_addr_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               halted_o,
    output logic               stack_err_o
);
    state_e state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, ret_addr;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic err_q, err_d, push, pop, full, empty;

    assign pc_inc = pc_q + 1'b1;

    call_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
        .clk(clk),
        .rst(rst),
        .push_i(push),
        .pop_i(pop),
        .din_i(pc_inc),
        .dout_o(ret_addr),
        .full_o(full),
        .empty_o(empty)
    );

    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        instr_d = instr_q;
        err_d = err_q;
        push = 1'b0;
        pop = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: if (mem_ack_i) begin
                instr_d = mem_data_i;
                state_d = mem_data_i == HALT_INSTR ? HALT : ISSUE;
            end
            ISSUE: state_d = EXEC;
            EXEC: if (exec_done_i) begin
                // ret outranks call, so a call+ret pair checks only for underflow
                if (ret_i ? empty : call_i && full) begin
                    err_d = 1'b1;
                    state_d = HALT;
                end else begin
                    pop = ret_i;
                    push = call_i && !ret_i;
                    pc_d = ret_i ? ret_addr : (call_i || jump_taken_i) ? jump_addr_i : pc_inc;
                    state_d = FETCH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q <= '0;
            instr_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            instr_q <= instr_d;
            err_q <= err_d;
        end
    end

    assign mem_req_o = state_q == FETCH;
    assign instr_valid_o = state_q == ISSUE;
    assign halted_o = state_q == HALT;
    assign mem_addr_o = pc_q;
    assign pc_o = pc_q;
    assign instr_o = instr_q;
    assign stack_err_o = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table, hand-written halt/reset sequences and
// randomized programs checked against an instruction-level reference model.
module tb_pc_sequencer;
    logic clk = 1'b0, rst = 1'b1;
    logic mem_req_o, mem_ack_i, instr_valid_o, exec_done_i, jump_taken_i, call_i, ret_i;
    logic halted_o, stack_err_o;
    logic [7:0] mem_addr_o, jump_addr_i, pc_o;
    logic [8:0] mem_data_i, instr_o;

    pc_sequencer dut (
        .clk(clk), .rst(rst),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .instr_o(instr_o), .instr_valid_o(instr_valid_o),
        .exec_done_i(exec_done_i), .jump_taken_i(jump_taken_i),
        .call_i(call_i), .ret_i(ret_i), .jump_addr_i(jump_addr_i),
        .pc_o(pc_o), .halted_o(halted_o), .stack_err_o(stack_err_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    logic [8:0] prog [256];
    logic [7:0] m_pc;
    logic [7:0] stk [$];
    bit m_halt, m_err;

    typedef struct {
        bit rs, c, r, j;
        logic [7:0] ja, pc;
        logic [1:0] he;
    } vec_t;
    vec_t tbl [24];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_in();
        mem_ack_i = 0; mem_data_i = 0; exec_done_i = 0;
        jump_taken_i = 0; call_i = 0; ret_i = 0; jump_addr_i = 0;
    endtask

    task automatic model_reset();
        m_pc = 0; stk.delete(); m_halt = 0; m_err = 0;
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {mem_req_o, instr_valid_o, halted_o, stack_err_o, mem_addr_o, pc_o, instr_o}, 0);
    endtask

    task automatic do_reset();
        rst = 1; clear_in();
        #2 chk_zero("reset_outputs");
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    // One full instruction: fetch with ad wait cycles, execute with ed wait cycles.
    task automatic do_instr(input int ad, input int ed, input bit c, input bit r,
                            input bit j, input logic [7:0] ja);
        logic [8:0] w;
        logic [7:0] nx;
        for (int n = 0; n < 8 && !mem_req_o; n++) tick();
        chk("fetch_req", mem_req_o, 1);
        chk("fetch_addr", mem_addr_o, m_pc);
        for (int i = 0; i < ad; i++) begin
            tick();
            chk("req_hold", {mem_req_o, mem_addr_o}, {1'b1, m_pc});
        end
        w = prog[m_pc];
        mem_ack_i = 1; mem_data_i = w;
        tick();
        mem_ack_i = 0; mem_data_i = 9'($urandom);
        if (w == 9'h1FF) begin
            m_halt = 1;
            chk("halt_fetch", {halted_o, instr_valid_o, mem_req_o, stack_err_o}, 4'b1000);
            return;
        end
        chk("issue", {instr_valid_o, instr_o}, {1'b1, w});
        tick();
        chk("exec_enter", {instr_valid_o, mem_req_o, instr_o}, {2'b00, w});
        for (int i = 0; i < ed; i++) begin
            call_i = 1'($urandom); ret_i = 1'($urandom);
            jump_taken_i = 1'($urandom); jump_addr_i = 8'($urandom);
            tick();
            chk("exec_wait", {instr_valid_o, mem_req_o, instr_o, pc_o}, {2'b00, w, m_pc});
        end
        exec_done_i = 1; call_i = c; ret_i = r; jump_taken_i = j; jump_addr_i = ja;
        tick();
        clear_in();
        nx = m_pc + 8'd1;
        if (r) begin
            if (stk.size() == 0) begin m_halt = 1; m_err = 1; end
            else m_pc = stk.pop_back();
        end else if (c) begin
            if (stk.size() == 4) begin m_halt = 1; m_err = 1; end
            else begin stk.push_back(nx); m_pc = ja; end
        end else begin
            m_pc = j ? ja : nx;
        end
        if (m_halt) chk("stack_halt", {halted_o, stack_err_o, mem_req_o, instr_valid_o, pc_o}, {4'b1100, m_pc});
        else chk("next_fetch", {mem_req_o, halted_o, mem_addr_o, pc_o}, {2'b10, m_pc, m_pc});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        clear_in();
        for (int a = 0; a < 256; a++) prog[a] = {1'b0, 8'(a) ^ 8'h5A};
        //           rs c  r  j  ja     next pc  {halted,err}
        tbl = '{
            '{1, 0, 0, 0, 8'h00, 8'h01, 2'd0}, '{0, 0, 0, 0, 8'hAA, 8'h02, 2'd0},
            '{0, 0, 0, 0, 8'h00, 8'h03, 2'd0}, '{0, 0, 0, 0, 8'h00, 8'h04, 2'd0},
            '{0, 0, 0, 0, 8'h00, 8'h05, 2'd0}, '{0, 1, 0, 0, 8'h40, 8'h40, 2'd0},
            '{0, 0, 0, 0, 8'h00, 8'h41, 2'd0}, '{0, 0, 0, 0, 8'h00, 8'h42, 2'd0},
            '{0, 0, 1, 0, 8'h00, 8'h06, 2'd0}, '{0, 0, 0, 1, 8'h10, 8'h10, 2'd0},
            '{0, 0, 0, 1, 8'hFF, 8'hFF, 2'd0}, '{0, 0, 0, 0, 8'h00, 8'h00, 2'd0},
            '{0, 1, 0, 0, 8'h20, 8'h20, 2'd0}, '{0, 1, 0, 0, 8'h30, 8'h30, 2'd0},
            '{0, 1, 0, 0, 8'h50, 8'h50, 2'd0}, '{0, 1, 1, 0, 8'h77, 8'h31, 2'd0},
            '{0, 0, 1, 0, 8'h00, 8'h21, 2'd0}, '{0, 0, 1, 0, 8'h00, 8'h01, 2'd0},
            '{0, 0, 1, 0, 8'h00, 8'h01, 2'd3}, '{1, 1, 0, 0, 8'h10, 8'h10, 2'd0},
            '{0, 1, 0, 0, 8'h20, 8'h20, 2'd0}, '{0, 1, 0, 0, 8'h30, 8'h30, 2'd0},
            '{0, 1, 0, 1, 8'h40, 8'h40, 2'd0}, '{0, 1, 0, 0, 8'h50, 8'h40, 2'd3}
        };
        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            if (tbl[i].rs) do_reset();
            do_instr(0, 0, tbl[i].c, tbl[i].r, tbl[i].j, tbl[i].ja);
            chk($sformatf("tbl%0d_pc", i), pc_o, tbl[i].pc);
            chk($sformatf("tbl%0d_halt_err", i), {halted_o, stack_err_o}, tbl[i].he);
        end

        // Halt instruction: no issue, then every input is ignored.
        do_reset();
        prog[8'h77] = 9'h1FF;
        do_instr(0, 0, 0, 0, 1, 8'h77);
        do_instr(0, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            exec_done_i = 1; call_i = 1; ret_i = 1'(i); jump_taken_i = 1;
            jump_addr_i = 8'h33; mem_ack_i = 1; mem_data_i = 9'h012;
            tick();
            chk("halt_sticky", {halted_o, mem_req_o, instr_valid_o, stack_err_o, pc_o}, {4'b1000, 8'h77});
        end
        clear_in();
        prog[8'h77] = {1'b0, 8'h77 ^ 8'h5A};

        // Async reset while a fetch is pending, then an ack landing in IDLE.
        do_reset();
        for (int n = 0; n < 8 && !mem_req_o; n++) tick();
        #2 rst = 1;
        #1 chk_zero("rst_mid_fetch");
        @(negedge clk);
        rst = 0; mem_ack_i = 1; mem_data_i = 9'h1FF;
        tick();
        clear_in();
        model_reset();
        chk("idle_ack_ignored", {mem_req_o, halted_o, mem_addr_o, instr_o}, {2'b10, 8'h00, 9'h000});

        // Async reset during EXEC after a call: stack must come back empty.
        do_instr(0, 0, 1, 0, 0, 8'h30);
        mem_ack_i = 1; mem_data_i = prog[8'h30];
        tick();
        clear_in();
        tick();
        #2 rst = 1;
        #1 chk_zero("rst_mid_exec");
        @(negedge clk);
        rst = 0;
        model_reset();
        do_instr(0, 0, 0, 1, 0, 8'h00);

        for (int run = 0; run < 25; run++) begin
            for (int a = 0; a < 256; a++)
                prog[a] = ($urandom_range(0, 47) == 0) ? 9'h1FF : 9'($urandom_range(0, 9'h1FE));
            do_reset();
            for (int k = 0; k < 40 && !m_halt; k++)
                do_instr($urandom_range(0, 2), $urandom_range(0, 2),
                         $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                         $urandom_range(0, 3) == 0, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
